// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - post-adder normalise and round-to-nearest-even stage
// Normalises one bit per cycle, rounds RNE, and registers a packed result behind a valid/ready handshake.
module fp_normalize_round #(
  parameter int MW = 24,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW+3:0] in_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW-2:0] out_frac,
  output logic          out_zero,
  output logic          out_overflow,
  output logic          out_underflow
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  localparam logic [EW:0] EXP_ONE = {{EW{1'b0}}, 1'b1};
  localparam logic [EW:0] EXP_MAX = {1'b0, {EW{1'b1}}};

  state_t        r_state;
  state_t        w_next;

  logic          r_sign;
  logic [EW:0]   r_exp;
  logic [MW+3:0] r_sum;
  logic          r_zero;
  logic          r_uf;
  logic          r_of;

  logic          r_out_valid;
  logic          r_out_sign;
  logic [EW-1:0] r_out_exp;
  logic [MW-2:0] r_out_frac;
  logic          r_out_zero;
  logic          r_out_of;
  logic          r_out_uf;

  logic          w_carry;
  logic          w_is_zero;
  logic          w_msb;
  logic          w_exp_low;
  logic [MW-1:0] w_sig;
  logic          w_round_up;
  logic [MW:0]   w_sig_rnd;
  logic [EW:0]   w_exp_rnd;
  logic [MW-1:0] w_sig_fin;
  logic          w_accept;
  logic          w_out_fire;

  assign w_carry    = r_sum[MW+3];
  assign w_is_zero  = (r_sum == '0);
  assign w_msb      = r_sum[MW+2];
  assign w_exp_low  = (r_exp <= EXP_ONE);
  assign w_sig      = r_sum[MW+2:3];
  assign w_round_up = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
  assign w_sig_rnd  = {1'b0, w_sig} + {{MW{1'b0}}, w_round_up};
  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_out_fire = r_out_valid && out_ready;

  // A rounding carry out of the significand renormalises to 1.000... with exp+1.
  always_comb begin
    w_sig_fin = w_sig_rnd[MW-1:0];
    w_exp_rnd = r_exp;
    if (w_sig_rnd[MW]) begin
      w_sig_fin = {1'b1, {(MW-1){1'b0}}};
      w_exp_rnd = r_exp + EXP_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_next = NORM;
      end
      NORM: begin
        if (w_carry)        w_next = ROUND;
        else if (w_is_zero) w_next = OUT;
        else if (w_msb)     w_next = ROUND;
        else if (w_exp_low) w_next = ROUND;
        else                w_next = NORM;
      end
      ROUND: begin
        w_next = OUT;
      end
      OUT: begin
        if (w_out_fire) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_sum  <= '0;
      r_zero <= 1'b0;
      r_uf   <= 1'b0;
      r_of   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign <= in_sign;
            r_exp  <= {1'b0, in_exp};
            r_sum  <= in_sum;
            r_zero <= 1'b0;
            r_uf   <= 1'b0;
            r_of   <= 1'b0;
          end
        end
        NORM: begin
          if (w_carry) begin
            // Bits shifted out on the right must stay visible to rounding via sticky.
            r_sum <= {1'b0, r_sum[MW+3:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + EXP_ONE;
          end else if (w_is_zero) begin
            r_zero <= 1'b1;
            r_exp  <= '0;
          end else if (w_msb) begin
            r_exp <= r_exp;
          end else if (w_exp_low) begin
            r_uf  <= 1'b1;
            r_exp <= '0;
          end else begin
            r_sum <= {r_sum[MW+2:0], 1'b0};
            r_exp <= r_exp - EXP_ONE;
          end
        end
        ROUND: begin
          if (w_exp_rnd >= EXP_MAX) begin
            r_exp <= EXP_MAX;
            r_sum <= {1'b0, 1'b1, {(MW-1){1'b0}}, 3'b000};
            r_of  <= 1'b1;
          end else begin
            r_exp <= w_exp_rnd;
            r_sum <= {1'b0, w_sig_fin, 3'b000};
          end
        end
        default: begin
          r_exp <= r_exp;
        end
      endcase
    end
  end

  // Output registers load on the first OUT cycle and then hold until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_frac  <= '0;
      r_out_zero  <= 1'b0;
      r_out_of    <= 1'b0;
      r_out_uf    <= 1'b0;
    end else if (r_state == OUT) begin
      if (!r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_sign  <= r_sign;
        r_out_exp   <= r_exp[EW-1:0];
        r_out_frac  <= r_sum[MW+1:3];
        r_out_zero  <= r_zero;
        r_out_of    <= r_of & ~r_zero;
        r_out_uf    <= r_uf & ~r_zero;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign out_valid     = r_out_valid;
  assign out_sign      = r_out_sign;
  assign out_exp       = r_out_exp;
  assign out_frac      = r_out_frac;
  assign out_zero      = r_out_zero;
  assign out_overflow  = r_out_of;
  assign out_underflow = r_out_uf;

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - directed vector bench for fp_normalize_round
// Table of hand-computed vectors plus backpressure and mid-operation reset sequences.
module tb_fp_normalize_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_zero;
  logic        out_overflow;
  logic        out_underflow;

  int n_chk;
  int n_fail;

  fp_normalize_round #(.MW(24), .EW(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sign(in_sign),
    .in_exp(in_exp),
    .in_sum(in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sign(out_sign),
    .out_exp(out_exp),
    .out_frac(out_frac),
    .out_zero(out_zero),
    .out_overflow(out_overflow),
    .out_underflow(out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp_in;
    logic [27:0] sum;
    logic [7:0]  e_exp;
    logic [22:0] e_frac;
    logic        e_zero;
    logic        e_of;
    logic        e_uf;
    int          e_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, "_sign"}, {31'b0, out_sign}, {31'b0, v.sign});
    chk({tag, "_exp"},  {24'b0, out_exp},  {24'b0, v.e_exp});
    chk({tag, "_frac"}, {9'b0, out_frac},  {9'b0, v.e_frac});
    chk({tag, "_flags"}, {29'b0, out_zero, out_overflow, out_underflow},
        {29'b0, v.e_zero, v.e_of, v.e_uf});
  endtask

  // Called #1 after a posedge; returns #1 after the edge that raised out_valid.
  task automatic send_and_wait(input vec_t v, input string tag, output int lat);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp_in;
    in_sum   = v.sum;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sum   = '0;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    chk({tag, "_latency"}, lat, v.e_lat);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_ready_rise"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_exp = '0;
    in_sum = '0;
    out_ready = 1'b0;

    //         sign  exp    sum           e_exp  e_frac      z  of uf lat
    vecs[0]  = '{1'b0, 8'd127, 28'h8000000, 8'd128, 23'h000000, 0, 0, 0, 3};
    vecs[1]  = '{1'b0, 8'd127, 28'h0000008, 8'd104, 23'h000000, 0, 0, 0, 26};
    vecs[2]  = '{1'b0, 8'd127, 28'h400000C, 8'd127, 23'h000002, 0, 0, 0, 3};
    vecs[3]  = '{1'b0, 8'd127, 28'h4000004, 8'd127, 23'h000000, 0, 0, 0, 3};
    vecs[4]  = '{1'b0, 8'd10,  28'h7FFFFFE, 8'd11,  23'h000000, 0, 0, 0, 3};
    vecs[5]  = '{1'b1, 8'd254, 28'h8000000, 8'd255, 23'h000000, 0, 1, 0, 3};
    vecs[6]  = '{1'b1, 8'd50,  28'h0000000, 8'd0,   23'h000000, 1, 0, 0, 2};
    vecs[7]  = '{1'b0, 8'd1,   28'h2000000, 8'd0,   23'h400000, 0, 0, 1, 3};
    vecs[8]  = '{1'b0, 8'd127, 28'h200000C, 8'd126, 23'h000003, 0, 0, 0, 4};
    vecs[9]  = '{1'b0, 8'd127, 28'h4000006, 8'd127, 23'h000001, 0, 0, 0, 3};
    vecs[10] = '{1'b1, 8'd100, 28'h8000018, 8'd101, 23'h000002, 0, 0, 0, 3};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_outputs", {8'b0, out_sign, out_exp, out_frac},  32'd0);
    chk("reset_flags", {29'b0, out_zero, out_overflow, out_underflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      send_and_wait(vecs[i], tag, lat);
      if (lat < 60) begin
        chk_outputs(tag, vecs[i]);
        drain(tag);
      end
    end

    // Backpressure: result must sit unchanged while out_ready is low.
    send_and_wait(vecs[2], "bp", lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", c), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
      chk_outputs($sformatf("bp%0d", c), vecs[2]);
    end
    drain("bp");

    // Reset during normalisation abandons the transaction.
    in_valid = 1'b1;
    in_sign  = vecs[1].sign;
    in_exp   = vecs[1].exp_in;
    in_sum   = vecs[1].sum;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_busy", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("rst_mid_no_result", seen, 32'd0);
    chk("rst_mid_idle", {31'b0, in_ready}, 32'd1);

    // Block still works after the abandoned transaction.
    send_and_wait(vecs[0], "post_rst", lat);
    if (lat < 60) begin
      chk_outputs("post_rst", vecs[0]);
      drain("post_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Post-adder stage of the floating-point add/sub datapath.
- Consumes the raw significand sum from the N-bit adder (carry-out plus sum, with guard/round/sticky bits) together with the pre-aligned exponent and sign.
- Iteratively normalises the sum one bit per cycle, applies round-to-nearest-even, and emits a packed IEEE-754-style result.
- Uses a valid/ready handshake on both sides.

Parameters:
- MW, 24, significand width including hidden bit.
- EW, 8, exponent width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  input transaction valid
- in_ready  output  1  block can accept input
- in_sign  input  1  result sign
- in_exp  input  EW  biased exponent before normalisation
- in_sum  input  MW+4  {carry, significand[MW-1:0], G, R, S}
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sign  output  1  result sign
- out_exp  output  EW  normalised biased exponent
- out_frac  output  MW-1  fraction, hidden bit dropped
- out_zero  output  1  result is exactly zero
- out_overflow  output  1  exponent saturated to all-ones (infinity)
- out_underflow  output  1  result is subnormal (exponent 0)

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is asynchronous and active-high. It forces state IDLE, in_ready=1, out_valid=0, and every other output and internal register to 0.
- Reset mid-operation abandons the transaction; no result is emitted.
- Internal exponent register is EW+1 bits so that increment and decrement never wrap.
- States: IDLE, NORM, ROUND, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, capture sign, exponent and sum; go to NORM.
  - in_ready is 0 in every other state.
- NORM, evaluated once per cycle in this priority order:
  - Carry bit set: shift sum right by 1, OR the dropped bit into S, exp+1; go to ROUND.
  - Sum all zero: set zero flag, exp=0; go to OUT.
  - Significand MSB (bit MW+2) set: go to ROUND.
  - exp <= 1: set underflow flag, exp=0; go to ROUND.
  - Otherwise: shift whole vector left by 1, LSB=0, exp-1; stay in NORM.
- ROUND (round-to-nearest-even):
  - LSB=bit3, G=bit2, R=bit1, S=bit0; round_up = G & (R | S | LSB).
  - significand += round_up.
  - If the significand overflows MW bits: set it to the MSB-only pattern and exp+1.
  - Then, if exp >= 2^EW-1: exp=all-ones, fraction=0, overflow flag set.
  - Go to OUT.
- OUT:
  - out_valid=1; all out_* are registered and held stable while out_valid & !out_ready.
  - On out_ready: go to IDLE. out_valid drops on the next cycle and in_ready rises.
  - No new input is accepted in the same cycle as output acceptance.
- Latency, counted from the accept edge to the edge that raises out_valid:
  - Carry or already-normalised sum: 3 cycles.
  - L left shifts: 3+L cycles.
  - Zero: 2 cycles.
  - Maximum: 3+(MW-1).
- Flag exclusivity: out_zero, out_overflow and out_underflow are mutually exclusive.
  - Zero takes precedence.
  - out_sign passes through unchanged, including for zero.

Test Plan:
- Carry normalise: in_exp=127, in_sum={1,24'h000000,3'b000} -> out_exp=128, out_frac=0, out_valid 3 cycles after accept, no flags.
- Cancellation: in_exp=127, significand 24'h000001, GRS=000 -> 23 left shifts, out_exp=104, out_frac=0, out_valid 26 cycles after accept.
- RNE ties, exp=127:
  - Significand 24'h800001, GRS=100 -> fraction 23'h000002 (rounds to even).
  - Significand 24'h800000, GRS=100 -> fraction 0 (stays even).
- Rounding carry: in_exp=10, significand 24'hFFFFFF, GRS=110 -> out_exp=11, out_frac=0.
- Overflow/zero/underflow:
  - in_exp=254 with carry set -> out_exp=255, out_frac=0, out_overflow=1.
  - All-zero sum -> out_zero=1, out_exp=0.
  - in_exp=1, significand 24'h400000 -> out_underflow=1, out_exp=0.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
  - Assert rst while in NORM -> out_valid=0, in_ready=1 immediately, with no result emitted afterwards.
